// File: rtl/signed_div_sched_pkg.sv
// rtl/signed_div_sched_pkg.sv - shared types and restoring-division step for the divider
package div_pkg;

    localparam int DIV_W     = 4;
    localparam int DIV_N_REQ = 3;

    typedef struct packed {
        logic             sign;
        logic [DIV_W-1:0] mag;
    } sm_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    typedef struct packed {
        logic [DIV_W-1:0] rem;
        logic [DIV_W-1:0] quo;
    } div_acc_t;

    // One restoring iteration: shift {rem,quo} left, trial-subtract the divisor at W+1 bits.
    function automatic div_acc_t div_step(input div_acc_t acc, input logic [DIV_W-1:0] dvs);
        logic [DIV_W:0] rem_s;
        logic [DIV_W:0] t;
        div_acc_t       nxt;
        rem_s   = {acc.rem, acc.quo[DIV_W-1]};
        t       = rem_s - {1'b0, dvs};
        nxt.rem = t[DIV_W] ? rem_s[DIV_W-1:0] : t[DIV_W-1:0];
        nxt.quo = {acc.quo[DIV_W-2:0], ~t[DIV_W]};
        return nxt;
    endfunction

endpackage

// File: rtl/signed_div_sched_if.sv
// rtl/signed_div_sched_if.sv - request/response bundle between issue ports and the shared divider
interface signed_div_sched_if #(
    parameter int N_REQ = div_pkg::DIV_N_REQ,
    parameter int W     = div_pkg::DIV_W
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*(W+1)-1:0] req_a;
    logic [N_REQ*(W+1)-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [W:0]             rsp_q;
    logic [W:0]             rsp_r;
    logic                   rsp_dz;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, busy
    );

endinterface

// File: rtl/signed_div_sched_rr_arbiter.sv
// rtl/signed_div_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_any
);
    localparam int IW = $clog2(N_REQ);

    always_comb begin : pick
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/signed_div_sched.sv
// rtl/signed_div_sched.sv - shared sign-magnitude restoring divider with round-robin issue
module signed_div_sched
    import div_pkg::*;
#(
    parameter int N_REQ = DIV_N_REQ,
    parameter int W     = DIV_W
) (
    input  logic               clk,
    input  logic               rst_n,
    signed_div_sched_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(W);

    div_state_e       state, state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    id_q;
    sm_t              a_q, b_q;
    div_acc_t         acc;
    logic             dz_q;
    logic [CW-1:0]    cnt;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    sm_t              a_sel, b_sel;
    logic             accept;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign a_sel  = bus.req_a[grant_idx*(W+1) +: (W+1)];
    assign b_sel  = bus.req_b[grant_idx*(W+1) +: (W+1)];
    assign accept = (state == IDLE) && grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_any) state_nxt = (b_sel.mag == '0) ? DONE : RUN;
            RUN:     if (cnt == CW'(W-1)) state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero parks |A| in rem so the remainder path needs no special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            dz_q   <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            rr_ptr  <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            id_q    <= grant_idx;
            a_q     <= a_sel;
            b_q     <= b_sel;
            cnt     <= '0;
            dz_q    <= (b_sel.mag == '0);
            acc.rem <= (b_sel.mag == '0) ? a_sel.mag : '0;
            acc.quo <= (b_sel.mag == '0) ? '0 : a_sel.mag;
        end else if (state == RUN) begin
            acc <= div_step(acc, b_q.mag);
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_dz    = dz_q;
    assign bus.rsp_q     = {(a_q.sign ^ b_q.sign) & (|acc.quo), acc.quo};
    assign bus.rsp_r     = {a_q.sign & (|acc.rem), acc.rem};

endmodule
